// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int          INST_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, inst} entries with a registered head.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    fetch_entry_t mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, fills the prefetch buffer from imem,
// and handles redirects and sticky fetch faults.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

    logic [31:0]  fetch_pc;
    logic         full;
    logic         empty;
    logic         pop;
    logic         can_push;
    logic         in_range;
    logic         push;
    fetch_entry_t din;
    fetch_entry_t head;

    assign imem_addr  = fetch_pc;
    assign inst_valid = !empty;
    assign inst_pc    = head.pc;
    assign inst_data  = head.inst;

    assign pop      = inst_valid && inst_ready;
    assign can_push = (!full || pop) && !fetch_fault && !redirect_valid;
    assign in_range = ({1'b0, fetch_pc} < PC_LIMIT);
    assign push     = can_push && in_range;
    assign din      = '{pc: fetch_pc, inst: imem_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Redirect outranks everything; only the first fault is latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00 && !fetch_fault) begin
                fetch_fault <= 1'b1;
                fault_pc    <= redirect_pc;
            end
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'(INST_BYTES);
        end else if (can_push) begin
            fetch_fault <= 1'b1;
            fault_pc    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: queue scoreboard of expected fetches.
module tb_imem_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;
    int pop_count = 0;
    int p0;
    fetch_entry_t exp_q[$];

    always #5 clk = ~clk;

    assign imem_data = 32'h1000_0000 + (imem_addr >> 2);

    imem_fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(1024), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] start_pc, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] p;
            p = start_pc + 32'(4 * i);
            exp_q.push_back('{pc: p, inst: 32'h1000_0000 + (p >> 2)});
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        repeat (n) step();
        rst = 1'b0;
    endtask

    // Accepted heads are compared against the scoreboard; a pop under redirect is flushed.
    always @(negedge clk) begin
        if (!rst && !redirect_valid && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_pop", {31'b0, inst_valid}, 32'd0);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                check("pop_pc", inst_pc, e.pc);
                check("pop_data", inst_data, e.inst);
            end
            pop_count++;
        end
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;

        // Reset values, then streaming at full rate.
        step();
        @(negedge clk);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_data", inst_data, 32'd0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst_fault_pc", fault_pc, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        step();
        rst = 1'b0;
        exp_q.delete();
        push_exp(32'h0, 40);
        @(negedge clk);
        check("lat_c1_valid", {31'b0, inst_valid}, 32'd0);
        step();
        @(negedge clk);
        check("lat_c2_valid", {31'b0, inst_valid}, 32'd1);
        check("lat_c2_pc", inst_pc, 32'h0);
        step();
        p0 = pop_count;
        repeat (8) step();
        check("stream_no_gaps", 32'(pop_count - p0), 32'd8);

        // Backpressure from the first valid cycle.
        inst_ready = 1'b0;
        do_reset(2);
        push_exp(32'h0, 40);
        step();
        repeat (4) step();
        @(negedge clk);
        check("bp_addr", imem_addr, 32'h8);
        check("bp_head_pc", inst_pc, 32'h0);
        check("bp_valid", {31'b0, inst_valid}, 32'd1);
        step();
        inst_ready = 1'b1;
        p0 = pop_count;
        repeat (6) step();
        check("bp_release_pops", 32'(pop_count - p0), 32'd6);

        // Redirect while the buffer is full and decode is ready.
        inst_ready = 1'b0;
        repeat (2) step();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        exp_q.delete();
        push_exp(32'h40, 40);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_valid", {31'b0, inst_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h40);
        step();
        @(negedge clk);
        check("redir_pc", inst_pc, 32'h40);
        check("redir_data", inst_data, 32'h1000_0010);
        repeat (4) step();

        // Reset pulse with two entries buffered.
        inst_ready = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        push_exp(32'h0, 40);
        inst_ready = 1'b1;
        @(negedge clk);
        check("mrst_valid", {31'b0, inst_valid}, 32'd0);
        check("mrst_fault", {31'b0, fetch_fault}, 32'd0);
        check("mrst_addr", imem_addr, 32'h0);
        step();
        p0 = pop_count;
        repeat (4) step();
        check("mrst_resume_pops", 32'(pop_count - p0), 32'd4);

        // Misaligned redirect faults; a later redirect does not clear it.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h46;
        exp_q.delete();
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("mis_fault", {31'b0, fetch_fault}, 32'd1);
        check("mis_fault_pc", fault_pc, 32'h46);
        check("mis_valid", {31'b0, inst_valid}, 32'd0);
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("mis_sticky", {31'b0, fetch_fault}, 32'd1);
        check("mis_first_pc", fault_pc, 32'h46);
        check("mis_addr", imem_addr, 32'h80);
        check("mis_no_valid", {31'b0, inst_valid}, 32'd0);

        // Fetch runs off the end of memory.
        do_reset(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFF8;
        push_exp(32'hFF8, 2);
        step();
        redirect_valid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("oor_fault", {31'b0, fetch_fault}, 32'd1);
        check("oor_fault_pc", fault_pc, 32'h1000);
        check("oor_valid", {31'b0, inst_valid}, 32'd0);
        check("oor_drained", 32'(exp_q.size()), 32'd0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
